// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a ready handshake,
// holds each instruction for decode, and selects the next PC on retire.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        retire_i,
  input  logic        PCSrc_i,
  input  logic [31:0] PCTarget_i,
  output logic        instr_valid_o,
  output logic [31:0] Instr_o,
  output logic [31:0] PC_o,
  output logic [31:0] PCPlus4_o,
  output logic [6:0]  op_o,
  output logic [2:0]  funct3_o,
  output logic        funct7b5_o,
  output logic        fetch_fault_o,
  output logic [31:0] retired_count_o
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pcPlus4;

  // PC+4 wraps naturally at 2^32; it feeds both the output and the sequential next PC
  assign pcPlus4 = pc_q + 32'd4;

  // State and datapath registers; reset parks the stage in IDLE with a NOP held
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      fault_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  // Next-state logic: capture on memory ready, redirect or fault on retire
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    fault_d = fault_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        if (imem_ready_i) begin
          instr_d = imem_rdata_i;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (retire_i) begin
          count_d = count_q + 32'd1;
          if (!PCSrc_i) begin
            pc_d    = pcPlus4;
            state_d = REQ;
          end else if (PCTarget_i[1:0] == 2'b00) begin
            pc_d    = PCTarget_i;
            state_d = REQ;
          end else begin
            fault_d = 1'b1;
            state_d = FAULT;
          end
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem_req_o      = (state_q == REQ);
  assign imem_addr_o     = pc_q;
  assign instr_valid_o   = (state_q == HOLD);
  assign Instr_o         = instr_q;
  assign PC_o            = pc_q;
  assign PCPlus4_o       = pcPlus4;
  assign op_o            = instr_q[6:0];
  assign funct3_o        = instr_q[14:12];
  assign funct7b5_o      = instr_q[30];
  assign fetch_fault_o   = fault_q;
  assign retired_count_o = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetch addresses and held
// instructions are queued by the stimulus and checked by separate monitors.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] op;
    logic [31:0] f3;
    logic [31:0] f7b5;
    logic [31:0] pc4;
    logic [31:0] cnt;
  } holdExp_t;

  logic        clk;
  logic        reset;
  logic        reqA;
  logic [31:0] addrA;
  logic        memReady;
  logic        forceReady;
  wire         imemReady = memReady | forceReady;
  logic [31:0] imemRdata;
  logic        retire;
  logic        pcSrc;
  logic [31:0] pcTarget;
  logic        validA;
  logic [31:0] instrA;
  logic [31:0] pcA;
  logic [31:0] pcPlus4A;
  logic [6:0]  opA;
  logic [2:0]  f3A;
  logic        f7A;
  logic        faultA;
  logic [31:0] countA;

  logic        reqB;
  logic [31:0] addrB;
  logic        bRetire;
  logic        validB;
  logic [31:0] instrB;
  logic [31:0] pcB;
  logic [31:0] pcPlus4B;
  logic [6:0]  opB;
  logic [2:0]  f3B;
  logic        f7B;
  logic        faultB;
  logic [31:0] countB;

  int checks = 0;
  int errors = 0;
  int cycleNo = 0;
  int lastRetireCycle = 0;

  logic        memHold;
  logic        memNop;
  logic [31:0] waitAddr;
  int          waitN;
  int          waitCnt;

  holdExp_t    holdQ[$];
  logic [31:0] addrQ[$];

  fetch_unit #(.RESET_PC(32'h0000_0000)) dutA (
    .clk_i(clk), .reset_i(reset),
    .imem_req_o(reqA), .imem_addr_o(addrA),
    .imem_ready_i(imemReady), .imem_rdata_i(imemRdata),
    .retire_i(retire), .PCSrc_i(pcSrc), .PCTarget_i(pcTarget),
    .instr_valid_o(validA), .Instr_o(instrA), .PC_o(pcA), .PCPlus4_o(pcPlus4A),
    .op_o(opA), .funct3_o(f3A), .funct7b5_o(f7A),
    .fetch_fault_o(faultA), .retired_count_o(countA)
  );

  // Second instance sits at the top of the address space to exercise PC wrap
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutB (
    .clk_i(clk), .reset_i(reset),
    .imem_req_o(reqB), .imem_addr_o(addrB),
    .imem_ready_i(reqB), .imem_rdata_i(32'h0000_0013),
    .retire_i(bRetire), .PCSrc_i(1'b0), .PCTarget_i(32'h0000_0000),
    .instr_valid_o(validB), .Instr_o(instrB), .PC_o(pcB), .PCPlus4_o(pcPlus4B),
    .op_o(opB), .funct3_o(f3B), .funct7b5_o(f7B),
    .fetch_fault_o(faultB), .retired_count_o(countB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleNo <= cycleNo + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a, input logic nop);
    if (nop) return 32'h0000_0013;
    case (a)
      32'h0000_0000: return 32'h4000_5033;
      32'h0000_0100: return 32'h0020_8063;
      default:       return 32'h0000_0013;
    endcase
  endfunction

  // Memory model: answers requests after the configured wait states and checks the fetch address
  always @(negedge clk) begin : responder
    logic [31:0] e;
    imemRdata = memWord(addrA, memNop);
    if (reset || !reqA || memHold) begin
      memReady = 1'b0;
      waitCnt  = 0;
    end else if (waitCnt < ((addrA == waitAddr) ? waitN : 0)) begin
      memReady = 1'b0;
      waitCnt++;
    end else begin
      memReady = 1'b1;
      waitCnt  = 0;
      if (addrQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL fetchAddr: unexpected request at %h", addrA);
      end else begin
        e = addrQ.pop_front();
        checkOutput("fetchAddr", addrA, e);
      end
    end
  end

  // Scoreboard monitor: each new held instruction is compared against the next expectation
  always @(negedge clk) begin : holdMonitor
    logic prevValid;
    holdExp_t h;
    if (reset) begin
      prevValid = 1'b0;
    end else begin
      if (validA && !prevValid) begin
        if (holdQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL hold: unexpected instruction at PC %h", pcA);
        end else begin
          h = holdQ.pop_front();
          checkOutput("holdPC", pcA, h.pc);
          checkOutput("holdInstr", instrA, h.instr);
          checkOutput("holdOp", 32'(opA), h.op);
          checkOutput("holdFunct3", 32'(f3A), h.f3);
          checkOutput("holdFunct7b5", 32'(f7A), h.f7b5);
          checkOutput("holdPCPlus4", pcPlus4A, h.pc4);
          checkOutput("holdCount", countA, h.cnt);
        end
      end
      prevValid = validA;
    end
  end

  task automatic waitValid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (validA) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL waitValid: got timeout expected instr_valid");
    end
  endtask

  task automatic applyStimulus(input logic src, input logic [31:0] tgt);
    bit ok;
    waitValid(ok);
    retire   = 1'b1;
    pcSrc    = src;
    pcTarget = tgt;
    lastRetireCycle = cycleNo;
    @(posedge clk);
    #1;
    retire   = 1'b0;
    pcSrc    = 1'b0;
    pcTarget = 32'h0;
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin : stimulus
    bit ok;
    int prevRetire;
    int reqCycles;
    reset = 1'b1; retire = 1'b0; pcSrc = 1'b0; pcTarget = 32'h0;
    forceReady = 1'b0; memHold = 1'b1; memNop = 1'b0;
    waitAddr = 32'h0; waitN = 0; bRetire = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rstPC", pcA, 32'h0);
    checkOutput("rstInstr", instrA, 32'h0000_0013);
    checkOutput("rstOp", 32'(opA), 32'h13);
    checkOutput("rstFunct3", 32'(f3A), 32'd0);
    checkOutput("rstFunct7b5", 32'(f7A), 32'd0);
    checkOutput("rstValid", 32'(validA), 32'd0);
    checkOutput("rstReq", 32'(reqA), 32'd0);
    checkOutput("rstFault", 32'(faultA), 32'd0);
    checkOutput("rstCount", countA, 32'd0);
    checkOutput("rstPCPlus4", pcPlus4A, 32'd4);
    checkOutput("rstAddr", addrA, 32'h0);

    // IDLE for one cycle, then REQ
    @(negedge clk) reset = 1'b0;
    checkOutput("idleReq", 32'(reqA), 32'd0);
    @(negedge clk);
    checkOutput("reqAsserted", 32'(reqA), 32'd1);
    checkOutput("reqAddr", addrA, 32'h0);

    // Reset lands in REQ while memory is ready in the same cycle
    @(negedge clk);
    forceReady = 1'b1;
    #2 reset = 1'b1;
    #1;
    checkOutput("midRstInstr", instrA, 32'h0000_0013);
    checkOutput("midRstValid", 32'(validA), 32'd0);
    checkOutput("midRstPC", pcA, 32'h0);
    checkOutput("midRstReq", 32'(reqA), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("midRstInstrHeld", instrA, 32'h0000_0013);

    // Response offered during IDLE must be discarded
    memHold = 1'b0;
    addrQ.push_back(32'h0);
    holdQ.push_back('{32'h0, 32'h4000_5033, 32'h33, 32'd5, 32'd1, 32'd4, 32'd0});
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    checkOutput("idleDiscardInstr", instrA, 32'h0000_0013);
    checkOutput("idleDiscardValid", 32'(validA), 32'd0);
    forceReady = 1'b0;

    // Retire stalls with PCSrc toggling leave PC and Instr frozen
    waitValid(ok);
    for (int i = 0; i < 3; i++) begin
      pcSrc = (i % 2 == 0);
      pcTarget = 32'h0000_0200;
      @(negedge clk);
      checkOutput("stallPC", pcA, 32'h0);
      checkOutput("stallInstr", instrA, 32'h4000_5033);
      checkOutput("stallValid", 32'(validA), 32'd1);
    end
    pcSrc = 1'b0;
    pcTarget = 32'h0;

    // Aligned redirect, then sequential, then misaligned redirect
    addrQ.push_back(32'h100);
    holdQ.push_back('{32'h100, 32'h0020_8063, 32'h63, 32'd0, 32'd0, 32'h104, 32'd1});
    applyStimulus(1'b1, 32'h0000_0100);
    addrQ.push_back(32'h104);
    holdQ.push_back('{32'h104, 32'h0000_0013, 32'h13, 32'd0, 32'd0, 32'h108, 32'd2});
    applyStimulus(1'b0, 32'h0);
    applyStimulus(1'b1, 32'h0000_0102);
    checkOutput("faultPC", pcA, 32'h104);
    checkOutput("faultCount", countA, 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("faultFlag", 32'(faultA), 32'd1);
      checkOutput("faultValid", 32'(validA), 32'd0);
      checkOutput("faultReq", 32'(reqA), 32'd0);
    end
    reset = 1'b1;
    #1;
    checkOutput("faultCleared", 32'(faultA), 32'd0);
    checkOutput("faultRstCount", countA, 32'd0);
    checkOutput("faultRstPC", pcA, 32'h0);

    // Zero-wait NOP stream with immediate retire
    memNop = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      addrQ.push_back(32'(4 * i));
      holdQ.push_back('{32'(4 * i), 32'h0000_0013, 32'h13, 32'd0, 32'd0, 32'(4 * i + 4), 32'(i)});
    end
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      prevRetire = lastRetireCycle;
      applyStimulus(1'b0, 32'h0);
      if (i > 0) checkOutput("retireSpacing", 32'(lastRetireCycle - prevRetire), 32'd2);
    end
    waitValid(ok);
    checkOutput("streamCount", countA, 32'd4);

    // Three wait states on address 0
    @(negedge clk) reset = 1'b1;
    memNop = 1'b0;
    waitAddr = 32'h0;
    waitN = 3;
    addrQ.push_back(32'h0);
    holdQ.push_back('{32'h0, 32'h4000_5033, 32'h33, 32'd5, 32'd1, 32'd4, 32'd0});
    @(negedge clk) reset = 1'b0;
    reqCycles = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (validA) break;
      if (reqA && addrA == 32'h0) reqCycles++;
    end
    checkOutput("waitReqCycles", 32'(reqCycles), 32'd4);
    checkOutput("waitValid", 32'(validA), 32'd1);
    checkOutput("waitInstr", instrA, 32'h4000_5033);

    // PC wrap on the instance reset to the top of memory
    checkOutput("wrapValid", 32'(validB), 32'd1);
    checkOutput("wrapPC", pcB, 32'hFFFF_FFFC);
    checkOutput("wrapPCPlus4", pcPlus4B, 32'h0);
    checkOutput("wrapInstr", instrB, 32'h0000_0013);
    checkOutput("wrapOp", 32'(opB), 32'h13);
    checkOutput("wrapFunct", {28'd0, f7B, f3B}, 32'd0);
    bRetire = 1'b1;
    @(posedge clk);
    #1 bRetire = 1'b0;
    @(negedge clk);
    checkOutput("wrapReq", 32'(reqB), 32'd1);
    checkOutput("wrapAddr", addrB, 32'h0);
    checkOutput("wrapCount", countB, 32'd1);
    checkOutput("wrapFault", 32'(faultB), 32'd0);

    checkOutput("addrQueueDrained", 32'(addrQ.size()), 32'd0);
    checkOutput("holdQueueDrained", 32'(holdQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
